// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
//
// Contents:
//   state_e       - controller state encoding (2'd3 is unused and recovers to idle)
//   DefaultWidth  - default operand/result width
package serial_sub_ctrl_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor: D = A - B - Bin, Bout set when the bit borrows.
//
// Ports:
//   A    - minuend bit
//   B    - subtrahend bit
//   Bin  - borrow in
//   D    - difference bit
//   Bout - borrow out
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  // Borrow when B exceeds A, or when the two are equal and a borrow comes in.
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller.
//
// A single full_subtractor is stepped across the operands LSB first, one bit per
// clock, with the borrow held in a register between bits. Operands are latched on
// an accepted start; the result appears on diff/bout together with a one-cycle
// done pulse WIDTH cycles after acceptance.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous reset, active high
//   start - operation request, only sampled while idle
//   a     - minuend, latched on accepted start
//   b     - subtrahend, latched on accepted start
//   bin   - borrow in, latched on accepted start
//   busy  - high while running or presenting the result
//   done  - one-cycle pulse, diff/bout newly valid
//   diff  - (a - b - bin) mod 2^WIDTH
//   bout  - borrow out of the MSB
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             borrow_q, borrow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Bin  (borrow_q),
    .D    (fs_d),
    .Bout (fs_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          res_sh_d = '0;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end

      StRun: begin
        // Result enters at the MSB so that after WIDTH shifts bit 0 sits at bit 0.
        res_sh_d = {fs_d, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = fs_bout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LastBit) begin
          // Outputs only update here, so partial results are never visible.
          diff_d  = res_sh_d;
          bout_d  = fs_bout;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Flag outputs are registered from the next state to keep them glitch free.
    busy_d = (state_d == StRun) || (state_d == StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       bin;
  logic       busy, done;
  logic [7:0] diff;
  logic       bout;

  logic       start4;
  logic [3:0] a4, b4;
  logic       bin4;
  logic       busy4, done4;
  logic [3:0] diff4;
  logic       bout4;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb8[$];
  logic [4:0] sb4[$];

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .bin   (bin4),
    .busy  (busy4),
    .done  (done4),
    .diff  (diff4),
    .bout  (bout4)
  );

  function automatic logic [8:0] ref9(input logic [7:0] av, input logic [7:0] bv,
                                      input logic bi);
    return {1'b0, av} - {1'b0, bv} - {8'd0, bi};
  endfunction

  function automatic logic [4:0] ref5(input logic [3:0] av, input logic [3:0] bv,
                                      input logic bi);
    return {1'b0, av} - {1'b0, bv} - {4'd0, bi};
  endfunction

  // Scoreboard monitors: every done pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb8.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done8: got {bout,diff}=%h, required no done", {bout, diff});
      end else begin
        logic [8:0] e;
        e = sb8.pop_front();
        if ({bout, diff} !== e) begin
          errors++;
          $display("FAIL result8: got {bout,diff}=%h, required %h", {bout, diff}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done4) begin
      checks++;
      if (sb4.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done4: got {bout,diff}=%h, required no done", {bout4, diff4});
      end else begin
        logic [4:0] e;
        e = sb4.pop_front();
        if ({bout4, diff4} !== e) begin
          errors++;
          $display("FAIL result4: got {bout,diff}=%h, required %h", {bout4, diff4}, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit op, then scramble the inputs; returns latency and busy cycles.
  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                        output int lat, output int busy_cnt);
    a = av; b = bv; bin = bi; start = 1'b1;
    sb8.push_back(ref9(av, bv, bi));
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff: got %h, required 00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout: got %b, required 0", bout); end
  endtask

  task automatic test_basic();
    int lat, bc;
    do_op8(8'h50, 8'h20, 1'b0, lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d, required 8", lat); end
    checks++; if (bc !== 9) begin errors++; $display("FAIL basic_busy_cycles: got %0d, required 9", bc); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL basic_idle_after: got busy=%b done=%b, required 0 0", busy, done);
    end
    checks++; if (diff !== 8'h30) begin errors++; $display("FAIL basic_diff_hold: got %h, required 30", diff); end
  endtask

  task automatic test_arith();
    int lat, bc;
    logic [7:0] av[3] = '{8'h20, 8'h00, 8'hFF};
    logic [7:0] bv[3] = '{8'h50, 8'h00, 8'hFF};
    logic       bi[3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op8(av[i], bv[i], bi[i], lat, bc);
      checks++; if (lat !== 8) begin errors++; $display("FAIL arith_latency%0d: got %0d, required 8", i, lat); end
    end
  endtask

  task automatic test_busy_ignore();
    int dones = 0;
    a = 8'h0F; b = 8'h01; bin = 1'b0; start = 1'b1;
    sb8.push_back(ref9(8'h0F, 8'h01, 1'b0));
    step();
    start = 1'b0;
    step();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (done) dones++;
      step();
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d, required 1", dones); end
    checks++; if (diff !== 8'h0E) begin errors++; $display("FAIL ignore_diff: got %h, required 0E", diff); end
  endtask

  task automatic test_reset_midop();
    int dones = 0;
    int lat, bc;
    a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b, required 0", done); end
    checks++; if (diff !== 8'h00) begin errors++; $display("FAIL midrst_diff: got %h, required 00", diff); end
    checks++; if (bout !== 1'b0) begin errors++; $display("FAIL midrst_bout: got %b, required 0", bout); end
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d, required 0", dones); end
    do_op8(8'h80, 8'h01, 1'b0, lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_new_latency: got %0d, required 8", lat); end
  endtask

  task automatic test_back_to_back();
    int t[3];
    int n = 0;
    int unstable = 0;
    a = 8'h10; b = 8'h03; bin = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) sb8.push_back(ref9(8'h10, 8'h03, 1'b0));
    for (int k = 0; k < 60 && n < 3; k++) begin
      step();
      if (n > 0 && diff !== 8'h0D) unstable++;
      if (done) begin
        t[n] = k;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    step(); step();
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d, required 3", n); end
    else begin
      checks++; if (t[1] - t[0] !== 10) begin errors++; $display("FAIL b2b_period1: got %0d, required 10", t[1] - t[0]); end
      checks++; if (t[2] - t[1] !== 10) begin errors++; $display("FAIL b2b_period2: got %0d, required 10", t[2] - t[1]); end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL b2b_diff_stable: got %0d changes, required 0", unstable); end
  endtask

  task automatic test_sweep4();
    int idx[512];
    int timeouts = 0;
    for (int i = 0; i < 512; i++) idx[i] = i;
    for (int i = 511; i > 0; i--) begin
      int j, tmp;
      j = int'($urandom_range(i, 0));
      tmp = idx[i]; idx[i] = idx[j]; idx[j] = tmp;
    end
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      bit got;
      v = 9'(idx[i]);
      a4 = v[8:5]; b4 = v[4:1]; bin4 = v[0]; start4 = 1'b1;
      sb4.push_back(ref5(v[8:5], v[4:1], v[0]));
      step();
      start4 = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        step();
        if (done4) begin got = 1'b1; break; end
      end
      if (!got) timeouts++;
      step();
    end
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL sweep4_timeouts: got %0d, required 0", timeouts); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_busy_ignore();
    test_reset_midop();
    test_back_to_back();
    test_sweep4();
    checks++; if (sb8.size() !== 0) begin errors++; $display("FAIL sb8_leftover: got %0d, required 0", sb8.size()); end
    checks++; if (sb4.size() !== 0) begin errors++; $display("FAIL sb4_leftover: got %0d, required 0", sb4.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
